// File: rtl/mrd_rdx3_stream.sv
// Radix-3 DFT butterfly: three-stage valid/ready pipeline with per-set inverse mode,
// rounded output right-shift, saturate or wrap, and a sticky overflow flag.
module mrd_rdx3_stream #(
  parameter int unsigned DW  = 16,
  parameter int unsigned CW  = 16,
  parameter bit          SAT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_inv,
  input  logic [1:0]      in_sh,
  input  logic [3*DW-1:0] din_real,
  input  logic [3*DW-1:0] din_imag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*DW-1:0] dout_real,
  output logic [3*DW-1:0] dout_imag,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int unsigned W1 = DW + 1;
  localparam int unsigned W2 = DW + 2;
  localparam int unsigned W3 = DW + 3;
  localparam int unsigned W4 = DW + 4;
  localparam int unsigned WP = DW + CW + 2;

  // K = round(sin(pi/3) * 2^(CW-1)) = round(sqrt(3 * 2^(2CW-4))), by integer square root.
  function automatic logic [63:0] calc_k(input int unsigned cw);
    logic [63:0] n;
    logic [63:0] r;
    logic [63:0] t;
    n = 64'd3 << (2 * cw - 4);
    r = '0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    if (n - r * r > r) r = r + 64'd1;
    return r;
  endfunction

  localparam logic [63:0]          KU   = calc_k(CW);
  localparam logic signed [WP-1:0] K    = $signed(WP'(KU));
  localparam logic signed [WP-1:0] RND  = $signed(WP'(64'd1 << (CW - 2)));
  localparam logic signed [W4-1:0] MAXV = $signed({5'b00000, {(DW-1){1'b1}}});
  localparam logic signed [W4-1:0] MINV = $signed({5'b11111, {(DW-1){1'b0}}});

  logic                 w_en;
  logic signed [DW-1:0] w_x_re [3];
  logic signed [DW-1:0] w_x_im [3];

  logic                 r1_valid, r1_inv;
  logic [1:0]           r1_sh;
  logic signed [W1-1:0] r1_s_re, r1_s_im, r1_d_re, r1_d_im;
  logic signed [DW-1:0] r1_a_re, r1_a_im;

  logic                 r2_valid, r2_inv;
  logic [1:0]           r2_sh;
  logic signed [W2-1:0] r2_y0_re, r2_y0_im, r2_m_re, r2_m_im;
  logic signed [W1-1:0] r2_r_re, r2_r_im;

  logic                 r_out_valid, r_ovf;
  logic [3*DW-1:0]      r_dout_real, r_dout_imag;

  logic signed [W1-1:0] w_h_re, w_h_im, w_r_re, w_r_im;
  logic signed [WP-1:0] w_p_re, w_p_im;
  logic signed [W3-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [W3-1:0] w_v [6];
  logic signed [W4-1:0] w_rnd;
  logic signed [W4-1:0] w_t [6];
  logic [DW-1:0]        w_o [6];
  logic                 w_of_any;

  assign w_en      = !r_out_valid || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign dout_real = r_dout_real;
  assign dout_imag = r_dout_imag;
  assign ovf       = r_ovf;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_x_re[i] = din_real[i*DW +: DW];
      w_x_im[i] = din_imag[i*DW +: DW];
    end
  end

  // Stage 2 combinational: floor half of s, and d*K rounded half-up back to W1 bits.
  assign w_h_re = r1_s_re >>> 1;
  assign w_h_im = r1_s_im >>> 1;
  assign w_p_re = WP'(r1_d_re) * K + RND;
  assign w_p_im = WP'(r1_d_im) * K + RND;
  assign w_r_re = W1'(w_p_re >>> (CW - 1));
  assign w_r_im = W1'(w_p_im >>> (CW - 1));

  // Lanes 0..2 are real X0..X2, lanes 3..5 imaginary; inverse swaps X1 and X2.
  always_comb begin
    w_a_re = W3'(r2_m_re) + W3'(r2_r_im);
    w_a_im = W3'(r2_m_im) - W3'(r2_r_re);
    w_b_re = W3'(r2_m_re) - W3'(r2_r_im);
    w_b_im = W3'(r2_m_im) + W3'(r2_r_re);
    w_v[0] = W3'(r2_y0_re);
    w_v[3] = W3'(r2_y0_im);
    w_v[1] = r2_inv ? w_b_re : w_a_re;
    w_v[4] = r2_inv ? w_b_im : w_a_im;
    w_v[2] = r2_inv ? w_a_re : w_b_re;
    w_v[5] = r2_inv ? w_a_im : w_b_im;
  end

  always_comb begin
    case (r2_sh)
      2'd1:    w_rnd = W4'(1);
      2'd2:    w_rnd = W4'(2);
      2'd3:    w_rnd = W4'(4);
      default: w_rnd = '0;
    endcase
    w_of_any = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_t[i] = (W4'(w_v[i]) + w_rnd) >>> r2_sh;
      w_o[i] = w_t[i][DW-1:0];
      if (w_t[i] > MAXV) begin
        w_of_any = 1'b1;
        if (SAT) w_o[i] = MAXV[DW-1:0];
      end else if (w_t[i] < MINV) begin
        w_of_any = 1'b1;
        if (SAT) w_o[i] = MINV[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r1_inv      <= 1'b0;
      r1_sh       <= '0;
      r1_s_re     <= '0;
      r1_s_im     <= '0;
      r1_d_re     <= '0;
      r1_d_im     <= '0;
      r1_a_re     <= '0;
      r1_a_im     <= '0;
      r2_valid    <= 1'b0;
      r2_inv      <= 1'b0;
      r2_sh       <= '0;
      r2_y0_re    <= '0;
      r2_y0_im    <= '0;
      r2_m_re     <= '0;
      r2_m_im     <= '0;
      r2_r_re     <= '0;
      r2_r_im     <= '0;
      r_out_valid <= 1'b0;
      r_dout_real <= '0;
      r_dout_imag <= '0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_en) begin
        r1_valid <= in_valid;
        if (in_valid) begin
          r1_inv  <= in_inv;
          r1_sh   <= in_sh;
          r1_s_re <= W1'(w_x_re[1]) + W1'(w_x_re[2]);
          r1_s_im <= W1'(w_x_im[1]) + W1'(w_x_im[2]);
          r1_d_re <= W1'(w_x_re[1]) - W1'(w_x_re[2]);
          r1_d_im <= W1'(w_x_im[1]) - W1'(w_x_im[2]);
          r1_a_re <= w_x_re[0];
          r1_a_im <= w_x_im[0];
        end
        r2_valid <= r1_valid;
        if (r1_valid) begin
          r2_inv   <= r1_inv;
          r2_sh    <= r1_sh;
          r2_y0_re <= W2'(r1_a_re) + W2'(r1_s_re);
          r2_y0_im <= W2'(r1_a_im) + W2'(r1_s_im);
          r2_m_re  <= W2'(r1_a_re) - W2'(w_h_re);
          r2_m_im  <= W2'(r1_a_im) - W2'(w_h_im);
          r2_r_re  <= w_r_re;
          r2_r_im  <= w_r_im;
        end
        r_out_valid <= r2_valid;
        if (r2_valid) begin
          r_dout_real <= {w_o[2], w_o[1], w_o[0]};
          r_dout_imag <= {w_o[5], w_o[4], w_o[3]};
        end
      end
      // A new overflow beats a simultaneous clear.
      if (w_en && r2_valid && w_of_any) r_ovf <= 1'b1;
      else if (ovf_clr)                 r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mrd_rdx3_stream.sv
// Bench for mrd_rdx3_stream: directed sets push hand-computed results into a queue
// that an independent output monitor pops and compares.
module tb_mrd_rdx3_stream;

  localparam int DW = 16;
  localparam int NW = 6 * DW;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic            in_inv;
  logic [1:0]      in_sh;
  logic [3*DW-1:0] din_real;
  logic [3*DW-1:0] din_imag;
  logic            out_valid;
  logic            out_ready;
  logic [3*DW-1:0] dout_real;
  logic [3*DW-1:0] dout_imag;
  logic            ovf;
  logic            ovf_clr;

  always #5 clk = ~clk;

  mrd_rdx3_stream #(
    .DW (DW),
    .CW (16),
    .SAT(1'b1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_inv   (in_inv),
    .in_sh    (in_sh),
    .din_real (din_real),
    .din_imag (din_imag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout_real(dout_real),
    .dout_imag(dout_imag),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  logic [NW-1:0] exp_q [$];
  logic [NW-1:0] snap;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_popped = 0;

  task automatic check(input string name, input logic [NW-1:0] got, input logic [NW-1:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic logic [3*DW-1:0] p3(input int a, input int b, input int c);
    return {DW'(c), DW'(b), DW'(a)};
  endfunction

  // Enter just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic inv, input logic [1:0] sh, input logic [3*DW-1:0] xr,
                      input logic [3*DW-1:0] xi, input logic [3*DW-1:0] er,
                      input logic [3*DW-1:0] ei, input bit push);
    bit ok;
    in_valid = 1'b1;
    in_inv   = inv;
    in_sh    = sh;
    din_real = xr;
    din_imag = xi;
    if (push) exp_q.push_back({ei, er});
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    check("accept", NW'(ok), NW'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 64) begin
      @(posedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    check("drain", NW'(exp_q.size()), '0);
  endtask

  initial begin : monitor
    logic [NW-1:0] want;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got %h want none", {dout_imag, dout_real});
        end else begin
          want = exp_q.pop_front();
          check($sformatf("out_set%0d", n_popped), {dout_imag, dout_real}, want);
          n_popped++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inv    = 1'b0;
    in_sh     = '0;
    din_real  = '0;
    din_imag  = '0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    #1;
    check("rst_dout", {dout_imag, dout_real}, '0);
    check("rst_flags", NW'({out_valid, ovf}), '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 check("rst_in_ready", NW'(in_ready), NW'(1));
    @(posedge clk);
    #1;

    // Impulse on x0 and exact 3-cycle latency
    send(1'b0, 2'd0, p3(100, 0, 0), p3(0, 0, 0), p3(100, 100, 100), p3(0, 0, 0), 1'b1);
    @(negedge clk) check("lat_c1", NW'(out_valid), '0);
    @(negedge clk) check("lat_c2", NW'(out_valid), '0);
    @(negedge clk) check("lat_c3", NW'(out_valid), NW'(1));
    wait_drain();
    check("ovf_after_impulse", NW'(ovf), '0);

    // x1 impulse, forward then inverse
    send(1'b0, 2'd0, p3(0, 1000, 0), p3(0, 0, 0), p3(1000, -500, -500), p3(0, -866, 866), 1'b1);
    send(1'b1, 2'd0, p3(0, 1000, 0), p3(0, 0, 0), p3(1000, -500, -500), p3(0, 866, -866), 1'b1);
    wait_drain();
    check("ovf_after_x1", NW'(ovf), '0);

    // Saturation, sticky flag, clear, then shifted version in range
    send(1'b0, 2'd0, p3(32767, 32767, 32767), p3(0, 0, 0), p3(32767, 0, 0), p3(0, 0, 0), 1'b1);
    wait_drain();
    check("ovf_set", NW'(ovf), NW'(1));
    ovf_clr = 1'b1;
    @(posedge clk);
    #1 ovf_clr = 1'b0;
    check("ovf_clr", NW'(ovf), '0);
    send(1'b0, 2'd2, p3(32767, 32767, 32767), p3(0, 0, 0), p3(24575, 0, 0), p3(0, 0, 0), 1'b1);
    wait_drain();
    check("ovf_sh2", NW'(ovf), '0);

    // Eight back-to-back sets with a four-cycle output stall
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(1'b0, 2'd0, p3(100 * i, 0, 2000), p3(10 * i, 0, 0),
               p3(100 * i + 2000, 100 * i - 1000, 100 * i - 1000),
               p3(10 * i, 10 * i + 1732, 10 * i - 1732), 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check($sformatf("stall_flags%0d", k), NW'({out_valid, in_ready}), NW'(2'b10));
          if (k == 0) snap = {dout_imag, dout_real};
          else check($sformatf("stall_hold%0d", k), {dout_imag, dout_real}, snap);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Per-set mode and shift
    send(1'b0, 2'd0, p3(0, 1000, 0), p3(0, 0, 0), p3(1000, -500, -500), p3(0, -866, 866), 1'b1);
    send(1'b1, 2'd1, p3(0, 1000, 0), p3(0, 0, 0), p3(500, -250, -250), p3(0, 433, -433), 1'b1);
    send(1'b0, 2'd3, p3(0, 1000, 0), p3(0, 0, 0), p3(125, -62, -62), p3(0, -108, 108), 1'b1);
    wait_drain();

    // Asynchronous reset with sets in flight
    send(1'b0, 2'd0, p3(32767, 32767, 32767), p3(0, 0, 0), p3(32767, 0, 0), p3(0, 0, 0), 1'b1);
    wait_drain();
    check("ovf_pre_rst", NW'(ovf), NW'(1));
    send(1'b0, 2'd0, p3(5, 0, 0), p3(5, 0, 0), '0, '0, 1'b0);
    send(1'b0, 2'd0, p3(6, 0, 0), p3(6, 0, 0), '0, '0, 1'b0);
    send(1'b0, 2'd0, p3(7, 0, 0), p3(7, 0, 0), '0, '0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("arst_flags", NW'({out_valid, ovf}), '0);
    check("arst_dout", {dout_imag, dout_real}, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("post_rst_in_ready", NW'(in_ready), NW'(1));
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_stale", NW'(seen), '0);
    @(posedge clk);
    #1;

    // Most-negative inputs: X0 clamps low, X1/X2 exact zero
    send(1'b0, 2'd0, p3(-32768, -32768, -32768), p3(-32768, -32768, -32768),
         p3(-32768, 0, 0), p3(-32768, 0, 0), 1'b1);
    wait_drain();
    check("ovf_neg", NW'(ovf), NW'(1));
    check("sets_out", NW'(n_popped), NW'(18));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mrd_rdx3_stream.md
Name: mrd_rdx3_stream

Overview:
- Parametrised radix-3 DFT butterfly for the mixed-radix FFT datapath; next generation of the fixed 18-bit radix-3 stage.
- Adds configurable data/coefficient width, per-sample forward/inverse mode, per-sample output scaling with rounding and saturation, a sticky overflow flag, and valid/ready backpressure.
- Sits between the twiddle-multiply stage and the stage reorder buffer.

Parameters:
- DW, 16: input and output sample width per real/imag component, two's complement.
- CW, 16: width of the sin60 constant; K = round(sin(pi/3) * 2^(CW-1)), giving 28378 at CW=16.
- SAT, 1: 1 = saturate outputs to DW; 0 = wrap (truncate MSBs).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample set valid
- in_ready  out  1  block can accept an input this cycle
- in_inv  in  1  0 = forward (W = e^-j2pi/3), 1 = inverse
- in_sh  in  2  output right-shift, 0..3
- din_real  in  3 x DW  x0..x2 real parts, signed
- din_imag  in  3 x DW  x0..x2 imaginary parts, signed
- out_valid  out  1  output sample set valid
- out_ready  in  1  downstream accepts output
- dout_real  out  3 x DW  X0..X2 real parts, signed
- dout_imag  out  3 x DW  X0..X2 imaginary parts, signed
- ovf  out  1  sticky flag: saturation or wrap occurred
- ovf_clr  in  1  synchronous clear of ovf

Behaviour:
- Reset (asynchronous, on rst high): all pipeline valids = 0; dout_real, dout_imag = 0; out_valid = 0; ovf = 0. Reset mid-stream discards all in-flight sets; in_ready is high on the first cycle after rst deasserts.
- Pipeline: 3 register stages. Global enable is en = !out_valid || out_ready, and in_ready = en.
  - Transfer occurs on in_valid && in_ready.
  - When en = 0, every stage holds, including bubbles, and dout and out_valid stay stable.
  - Latency is 3 clk with no stall; throughput is 1 set per clk.
- in_inv and in_sh are captured with the data and travel down the pipeline.
- Stage 1, complex, per component:
  - s = x1 + x2 (DW+1)
  - d = x1 - x2 (DW+1)
  - a = x0
- Stage 2:
  - y0 = a + s (DW+2)
  - h = s >>> 1 (floor)
  - m = a - h (DW+2)
  - r = (d*K + 2^(CW-2)) >>> (CW-1), round-half-up (DW+1)
- Stage 3, forward:
  - X0 = y0
  - X1 = (m_re + r_im, m_im - r_re)
  - X2 = (m_re - r_im, m_im + r_re)
- Stage 3, inverse: X1 and X2 are swapped.
- Output conversion per component:
  - v' = (v + (sh ? 2^(sh-1) : 0)) >>> sh
  - If SAT = 1, clamp to [-2^(DW-1), 2^(DW-1)-1]; otherwise keep the low DW bits.
  - ovf sets when any component of an accepted output set falls outside DW range.
- ovf behaviour:
  - ovf_clr clears ovf.
  - If ovf_clr and a new overflow occur in the same cycle, the set wins and ovf = 1.
  - ovf updates only when a stage-3 set is loaded, not during stalls.
- Boundaries:
  - in_valid = 0 while en = 1 inserts a bubble.
  - out_ready = 0 with out_valid = 0 never blocks input.
  - Most-negative inputs must not overflow the internal widths: intermediates at DW+2 and DW+1+CW bits are exact.

Test Plan:
- DW=16, fwd, sh=0, x0=(100,0), x1=x2=0 -> X0=X1=X2=(100,0); out_valid exactly 3 clk after accept; ovf=0.
- fwd, sh=0, x0=0, x1=(1000,0), x2=0 -> X0=(1000,0), X1=(-500,-866), X2=(-500,866); same stimulus with in_inv=1 -> X1=(-500,866), X2=(-500,-866).
- x0=x1=x2=(32767,0):
  - sh=0 -> X0=(32767,0) saturated, X1=X2=(0,0), ovf=1.
  - Then ovf_clr pulse, sh=2 -> X0=(24575,0), ovf stays 0.
- Stream 8 back-to-back sets with out_ready low for cycles 4-7 -> in_ready low while stalled, no set lost or duplicated, dout stable during stall, output order preserved.
- Alternate in_inv/in_sh per set (0/0, 1/1, 0/3) -> each output uses its own captured mode and shift.
- Assert rst for 1 clk with 3 sets in flight -> out_valid=0, dout=0, ovf=0 immediately (asynchronous); no stale outputs after release.
